reg_writeback: RTL

Write-side controller for the 32x32 integer register file. It accepts completed results from the ALU and load (memory) paths over valid/ready handshakes and buffers them in a small FIFO. It drains one result per cycle onto the register file's single write port (`rf_en`/`rf_wa`/`rf_wd`). It also keeps a per-register busy scoreboard so decode can stall on source registers whose pending writes have not yet committed.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_fifo.sv | 72 +++++++
 rtl/reg_writeback.sv | 90 +++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and widths for the register-file write-back path.
//   wb_entry_t  - one completed result: destination register + value
//   REG_ADDR_W  - register address width (32 registers)
//   XLEN        - register data width
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t results, strict arrival order.
//   clk, rst     - clock, asynchronous active-high reset (empties the FIFO)
//   push_i       - write push_data_i at the tail (ignored when full)
//   push_data_i  - entry to enqueue
//   pop_i        - drop the head entry (ignored when empty)
//   full_o       - DEPTH entries held
//   empty_o      - no entries held
//   head_o       - oldest entry, valid only while !empty_o
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  wb_entry_t push_data_i,
    input  logic      pop_i,
    output logic      full_o,
    output logic      empty_o,
    output wb_entry_t head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    wb_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: its contents are only visible through head_o
    // while the count says the slot is live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: write-side controller for the 32x32 integer register file.
// Buffers ALU and load results in a FIFO, drains one per cycle onto the
// single register-file write port, and keeps a per-register busy scoreboard
// so decode can stall on sources with uncommitted writes.
//   clk, rst                        - clock, async active-high reset
//   issue_valid, issue_rd           - decode issued a writer of issue_rd
//   alu_valid/alu_ready, alu_rd/data - ALU result handshake
//   mem_valid/mem_ready, mem_rd/data - load result handshake (priority)
//   wb_hold                         - write port unavailable this cycle
//   rf_en, rf_wa, rf_wd             - register file write port
//   chk_addr1, chk_addr2            - decode source registers
//   stall                           - a source register is busy
module reg_writeback
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  wb_hold,
    output logic                  rf_en,
    output logic [REG_ADDR_W-1:0] rf_wa,
    output logic [XLEN-1:0]       rf_wd,
    input  logic [REG_ADDR_W-1:0] chk_addr1,
    input  logic [REG_ADDR_W-1:0] chk_addr2,
    output logic                  stall
);

    logic      full, empty;
    logic      push, pop;
    logic      head_live;
    wb_entry_t push_data, head;
    logic [31:0] busy_q, busy_d;

    // Loads win; the ALU only gets the slot when no load is offered.
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;
    assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);

    always_comb begin
        push_data = '{rd: alu_rd, data: alu_data};
        if (mem_valid) push_data = '{rd: mem_rd, data: mem_data};
    end

    // The head leaves whenever the port is free; x0 entries leave too but
    // never reach the register file.
    assign pop       = !empty && !wb_hold;
    assign head_live = !empty && (head.rd != '0);

    assign rf_en = head_live && !wb_hold;
    assign rf_wa = head_live ? head.rd   : '0;
    assign rf_wd = head_live ? head.data : '0;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .head_o      (head)
    );

    // Clear before set so a same-cycle reissue keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (rf_en) busy_d[rf_wa] = 1'b0;
        if (issue_valid && issue_rd != '0) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign stall = busy_q[chk_addr1] || busy_q[chk_addr2];

endmodule
